// File: rtl/mod_dsha_seq.sv
// mod_dsha_seq: job sequencer for double-SHA256 header scanning.
// Drives the compression core command bus through a fixed step list.
// The midstate is computed once per job. The nonce range is then swept
// with a dynamic-block hash followed by a second hash, and every digest
// is checked against the target until the first hit, the end of the
// range, or an abort.
module mod_dsha_seq #(
  parameter logic [7:0] CMD_IDLE        = 8'd0,
  parameter logic [7:0] CMD_LOAD_H      = 8'd1,
  parameter logic [7:0] CMD_HASH        = 8'd2,
  parameter logic [7:0] CMD_SUM_STORE_H = 8'd3,
  parameter logic [7:0] CMD_SUM_STORE_M = 8'd4,
  parameter logic [7:0] CMD_GET_DIGEST  = 8'd5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         ABORT,
  input  logic [31:0]  NONCE_START,
  input  logic [31:0]  NONCE_END,
  input  logic [255:0] TARGET,
  output logic [7:0]   CMD,
  input  logic         RDY,
  input  logic [255:0] RES,
  output logic         H_BANK,
  output logic [1:0]   M_BANK,
  output logic [31:0]  NONCE_WORD,
  output logic         BUSY,
  output logic         DONE,
  output logic         FOUND,
  output logic [31:0]  FOUND_NONCE,
  output logic [255:0] DIGEST
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_CHECK} state_t;

  // Step order of one job: three midstate steps, then six per nonce.
  typedef enum logic [3:0] {
    ST_LOAD1, ST_HASH1, ST_STORE1,
    ST_LOAD2, ST_HASH2, ST_STORE2,
    ST_LOAD3, ST_HASH3, ST_DIG
  } step_t;

  state_t        r_state;
  step_t         r_step;
  logic [7:0]    r_cmd;
  logic          r_h_bank;
  logic [1:0]    r_m_bank;
  logic          r_busy;
  logic          r_done;
  logic          r_found;
  logic [31:0]   r_found_nonce;
  logic [255:0]  r_digest;
  logic [31:0]   r_nonce;
  logic [31:0]   r_nonce_end;
  logic [255:0]  r_target;
  logic [255:0]  r_res;

  logic          w_accept;
  logic          w_dig_done;
  logic          w_hit;
  logic          w_last;
  step_t         w_next_step;

  // Core command for each step.
  function automatic logic [7:0] step_cmd(input step_t s);
    case (s)
      ST_LOAD1, ST_LOAD2, ST_LOAD3: step_cmd = CMD_LOAD_H;
      ST_HASH1, ST_HASH2, ST_HASH3: step_cmd = CMD_HASH;
      ST_STORE1:                    step_cmd = CMD_SUM_STORE_H;
      ST_STORE2:                    step_cmd = CMD_SUM_STORE_M;
      ST_DIG:                       step_cmd = CMD_GET_DIGEST;
      default:                      step_cmd = CMD_IDLE;
    endcase
  endfunction

  // H read bank: midstate only while loading/storing the dynamic block pass.
  function automatic logic step_h_bank(input step_t s);
    step_h_bank = (s == ST_LOAD2) || (s == ST_STORE2);
  endfunction

  // Message block select: static, dynamic, or the 2nd-pass hash block.
  function automatic logic [1:0] step_m_bank(input step_t s);
    case (s)
      ST_HASH2: step_m_bank = 2'd1;
      ST_HASH3: step_m_bank = 2'd2;
      default:  step_m_bank = 2'd0;
    endcase
  endfunction

  // Little-endian word to big-endian word (nonce enters the header LE).
  function automatic logic [31:0] byte_swap32(input logic [31:0] x);
    byte_swap32 = {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Digest byte 0 becomes the most significant byte for the target compare.
  function automatic logic [255:0] byte_rev256(input logic [255:0] x);
    logic [255:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      y[8*i +: 8] = x[8*(31-i) +: 8];
    end
    byte_rev256 = y;
  endfunction

  assign w_accept    = (r_state == S_IDLE) && START && !r_done;
  assign w_dig_done  = (r_state == S_ISSUE) && (r_step == ST_DIG) && RDY;
  assign w_hit       = (byte_rev256(r_res) <= r_target);
  assign w_last      = (r_nonce == r_nonce_end);
  assign w_next_step = step_t'(r_step + 4'd1);

  // Job parameters and last digest are plain data; they need no reset.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_target    <= TARGET;
      r_nonce_end <= NONCE_END;
    end
    if (w_dig_done) begin
      r_res <= RES;
    end
  end

  // Sequencer FSM: issue a step, wait out the RDY handshake, check digests.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_step        <= ST_LOAD1;
      r_cmd         <= CMD_IDLE;
      r_h_bank      <= 1'b0;
      r_m_bank      <= 2'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_digest      <= '0;
      r_nonce       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A START coinciding with the DONE pulse is deliberately dropped.
          if (w_accept) begin
            r_nonce       <= NONCE_START;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_digest      <= '0;
            r_busy        <= 1'b1;
            r_step        <= ST_LOAD1;
            r_cmd         <= step_cmd(ST_LOAD1);
            r_h_bank      <= step_h_bank(ST_LOAD1);
            r_m_bank      <= step_m_bank(ST_LOAD1);
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Command and banks stay put until the core reports completion.
          if (RDY) begin
            r_cmd   <= CMD_IDLE;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          // Banks stay held; wait for the core to drop RDY before moving on.
          if (!RDY) begin
            if (ABORT) begin
              r_found  <= 1'b0;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_h_bank <= 1'b0;
              r_m_bank <= 2'd0;
              r_state  <= S_IDLE;
            end else if (r_step == ST_DIG) begin
              r_h_bank <= 1'b0;
              r_m_bank <= 2'd0;
              r_state  <= S_CHECK;
            end else begin
              r_step   <= w_next_step;
              r_cmd    <= step_cmd(w_next_step);
              r_h_bank <= step_h_bank(w_next_step);
              r_m_bank <= step_m_bank(w_next_step);
              r_state  <= S_ISSUE;
            end
          end
        end
        S_CHECK: begin
          if (ABORT) begin
            r_found <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_hit) begin
            r_found       <= 1'b1;
            r_found_nonce <= r_nonce;
            r_digest      <= r_res;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else if (w_last) begin
            r_found <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Midstate is reused: restart at the dynamic-block load.
            r_nonce  <= r_nonce + 32'd1;
            r_step   <= ST_LOAD2;
            r_cmd    <= step_cmd(ST_LOAD2);
            r_h_bank <= step_h_bank(ST_LOAD2);
            r_m_bank <= step_m_bank(ST_LOAD2);
            r_state  <= S_ISSUE;
          end
        end
        default: begin
          r_cmd   <= CMD_IDLE;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign CMD         = r_cmd;
  assign H_BANK      = r_h_bank;
  assign M_BANK      = r_m_bank;
  assign NONCE_WORD  = byte_swap32(r_nonce);
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign FOUND       = r_found;
  assign FOUND_NONCE = r_found_nonce;
  assign DIGEST      = r_digest;

endmodule
